// File: rtl/parity_rx_pkg.sv
// Shared types and sizing helpers for the even-parity frame receiver.
// Build option: PARITY_RX_SYNC_EN adds a two-flop input synchronizer in parity_frame_rx.
package parity_rx_pkg;

  // Receiver FSM states.
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } rx_state_e;

  // Width of a counter that must hold values 0..n-1 (never narrower than one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Half a bit period, used to land the start-bit sample at its centre.
  function automatic int unsigned half_bit(input int unsigned clks_per_bit);
    return clks_per_bit / 2;
  endfunction

  localparam int unsigned DefaultDataW      = 4;
  localparam int unsigned DefaultClksPerBit = 8;
  localparam int unsigned DefaultHalfBit    = half_bit(DefaultClksPerBit);
  localparam int unsigned DefaultCntW       = cnt_width(DefaultClksPerBit);
  localparam int unsigned DefaultIdxW       = cnt_width(DefaultDataW);

endpackage

// File: rtl/parity_bit_timer.sv
// Bit-period down-counter for the frame receiver. Loads a half-bit or full-bit
// count on request and raises tick while the count sits at zero (the sample point).
module parity_bit_timer
  import parity_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_half,
  input  logic load_full,
  output logic tick
);

  localparam int unsigned CntW = cnt_width(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfVal = CntW'(half_bit(CLKS_PER_BIT));
  localparam logic [CntW-1:0] FullVal = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q;

  // Count down to zero and hold there; a load always wins, half-bit has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= HalfVal;
    end else if (load_half) begin
      cnt_q <= HalfVal;
    end else if (load_full) begin
      cnt_q <= FullVal;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/parity_frame_rx.sv
// Even-parity serial frame receiver: start(0), DATA_W data bits LSB first,
// even parity, stop(1). Samples bit centres, reports parity and framing errors.
// Build option: PARITY_RX_SYNC_EN routes rx_in through a two-flop synchronizer.
module parity_frame_rx
  import parity_rx_pkg::*;
#(
  parameter int unsigned DATA_W       = 4,
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned IdxW = cnt_width(DATA_W);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_W - 1);

  logic rx_s;

`ifdef PARITY_RX_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchronizer, reset to the idle line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_in};
    end
  end

  assign rx_s = sync_q[1];
`else
  assign rx_s = rx_in;
`endif

  rx_state_e         state_q;
  logic [DATA_W-1:0] shift_q;
  logic [IdxW-1:0]   idx_q;
  logic              par_q;
  logic              tick;
  logic              load_half;
  logic              load_full;

  parity_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_half(load_half),
    .load_full(load_full),
    .tick     (tick)
  );

  // Timer control: keep the half-bit count preloaded whenever no frame is armed,
  // so the first low cycle in idle already counts toward the start sample.
  always_comb begin
    load_half = 1'b0;
    load_full = 1'b0;
    unique case (state_q)
      StIdle:  load_half = rx_s;
      StStart: begin
        if (tick) begin
          load_half = rx_s;
          load_full = ~rx_s;
        end
      end
      StData:   load_full = tick;
      StParity: load_full = tick;
      StStop:   load_half = tick;
      StBreak:  load_half = 1'b1;
      default:  load_half = 1'b1;
    endcase
  end

  // Frame FSM with shift register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      idx_q      <= '0;
      par_q      <= 1'b0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!rx_s) begin
            state_q <= StStart;
            idx_q   <= '0;
            busy    <= 1'b1;
          end
        end
        StStart: begin
          if (tick) begin
            if (rx_s) begin
              // Start bit gone by its centre: treat as a glitch.
              state_q <= StIdle;
              busy    <= 1'b0;
            end else begin
              state_q <= StData;
            end
          end
        end
        StData: begin
          if (tick) begin
            shift_q[idx_q] <= rx_s;
            if (idx_q == LastIdx) begin
              state_q <= StParity;
            end else begin
              idx_q <= idx_q + IdxW'(1);
            end
          end
        end
        StParity: begin
          if (tick) begin
            par_q   <= rx_s;
            state_q <= StStop;
          end
        end
        StStop: begin
          if (tick) begin
            data_out   <= shift_q;
            parity_err <= ^{shift_q, par_q};
            frame_err  <= ~rx_s;
            valid_out  <= 1'b1;
            // busy drops with valid_out even when a low stop bit sends us to BREAK.
            busy       <= 1'b0;
            state_q    <= rx_s ? StIdle : StBreak;
          end
        end
        StBreak: begin
          if (rx_s) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_frame_rx.sv
// Self-checking bench for parity_frame_rx: directed frames plus random frames,
// compared against expected pulses derived from the frame format.
module tb_parity_frame_rx;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned CLKS   = 8;
  localparam int          H      = CLKS / 2;
`ifdef PARITY_RX_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  // Cycle offset from the start edge to the visible valid_out pulse.
  localparam int VALID_LAT = H + (DATA_W + 2) * CLKS + 1 + SYNC;

  typedef struct {
    int                cyc;
    logic [DATA_W-1:0] d;
    logic              pe;
    logic              fe;
  } pulse_t;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              rx_in = 1'b1;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              parity_err;
  logic              frame_err;
  logic              busy;

  int     cyc = 0;
  int     n_checks = 0;
  int     n_pass = 0;
  int     n_fail = 0;
  pulse_t exp_q[$];
  pulse_t got_q[$];
  pulse_t mon_p;

  parity_frame_rx #(
    .DATA_W      (DATA_W),
    .CLKS_PER_BIT(CLKS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_in     (rx_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every cycle on which valid_out is high.
  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      mon_p.cyc = cyc;
      mon_p.d   = data_out;
      mon_p.pe  = parity_err;
      mon_p.fe  = frame_err;
      got_q.push_back(mon_p);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic b, input int n);
    rx_in = b;
    repeat (n) @(negedge clk);
  endtask

  // Send one frame; the expected pulse is derived from the frame contents.
  task automatic send_frame(input logic [DATA_W-1:0] d, input logic p, input logic s,
                            input int stop_len, input int hold_low);
    pulse_t e;
    e.cyc = cyc + VALID_LAT;
    e.d   = d;
    e.pe  = ^{d, p};
    e.fe  = ~s;
    exp_q.push_back(e);
    drive(1'b0, CLKS);
    for (int i = 0; i < DATA_W; i++) drive(d[i], CLKS);
    drive(p, CLKS);
    drive(s, stop_len);
    for (int i = 0; i < hold_low; i++) begin
      chk("break_busy", busy, 0);
      drive(1'b0, 1);
    end
    rx_in = 1'b1;
  endtask

  // Compare recorded pulses with expected ones, with a bounded wait.
  task automatic check_pulses(input string tag);
    int waited = 0;
    while (got_q.size() < exp_q.size() && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    repeat (4) @(negedge clk);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk({tag, "_cycle"}, got_q[i].cyc, exp_q[i].cyc);
      chk({tag, "_data"}, got_q[i].d, exp_q[i].d);
      chk({tag, "_parity_err"}, got_q[i].pe, exp_q[i].pe);
      chk({tag, "_frame_err"}, got_q[i].fe, exp_q[i].fe);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  // Abort a frame with reset 20 cycles after its start edge.
  task automatic reset_mid(input string tag);
    drive(1'b0, CLKS);
    drive(1'b1, 12);
    chk({tag, "_busy_pre"}, busy, 1);
    rst_n = 1'b0;
    #1;
    chk({tag, "_data_out"}, data_out, 0);
    chk({tag, "_valid_out"}, valid_out, 0);
    chk({tag, "_parity_err"}, parity_err, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
    chk({tag, "_busy"}, busy, 0);
    @(negedge clk);
    rx_in = 1'b1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_pulses(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] rd;
    logic              rp;
    logic              rs;
    int                sl;

    rst_n = 1'b0;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data_out", data_out, 0);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_parity_err", parity_err, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    reset_mid("rst_mid1");
    send_frame(4'hA, 1'b0, 1'b1, CLKS, 0);
    drive(1'b1, 3);
    check_pulses("frame_a");

    send_frame(4'hB, 1'b1, 1'b1, CLKS, 0);
    drive(1'b1, 2);
    check_pulses("frame_b_ok");

    send_frame(4'hB, 1'b0, 1'b1, CLKS, 0);
    drive(1'b1, 2);
    check_pulses("frame_b_perr");

    // data_out and parity_err are nonzero here, so the reset clear is visible.
    send_frame(4'hB, 1'b0, 1'b1, CLKS, 0);
    drive(1'b1, 2);
    check_pulses("frame_b_perr2");
    reset_mid("rst_mid2");

    send_frame(4'h0, 1'b0, 1'b0, CLKS, 30);
    drive(1'b1, 4);
    check_pulses("break");

    // Three-cycle low glitch on an idle line.
    rx_in = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k == 3) rx_in = 1'b1;
      if (k == 2 + SYNC) chk("glitch_busy_hi", busy, 1);
      if (k == 5 + SYNC) chk("glitch_idle", busy, 0);
      @(negedge clk);
    end
    repeat (60) @(negedge clk);
    check_pulses("glitch");

    // Second start edge on the first idle cycle after the stop sample.
    send_frame(4'h5, 1'b0, 1'b1, H + 1, 0);
    send_frame(4'hC, 1'b0, 1'b1, CLKS, 0);
    drive(1'b1, 2);
    check_pulses("b2b");

    for (int n = 0; n < 10; n++) begin
      rd = DATA_W'($urandom);
      rp = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 3) != 0);
      sl = rs ? int'($urandom_range(H + 1, CLKS)) : int'(CLKS);
      send_frame(rd, rp, rs, sl, 0);
      drive(1'b1, rs ? int'($urandom_range(0, 3)) : int'($urandom_range(2, 4)));
    end
    drive(1'b1, 2);
    check_pulses("rand");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
